// File: rtl/rom_load_sequencer_if.sv
// Bundle of loader, CPU fetch, BRAM port and status signals for rom_load_sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface rom_load_sequencer_if #(
    parameter int ROM_AW = 16,
    parameter int CNT_W  = 17
);
    logic              dn_download;
    logic              dn_wr;
    logic [15:0]       dn_addr;
    logic [7:0]        dn_data;
    logic              cpu_req;
    logic [ROM_AW-1:0] cpu_addr;
    logic [7:0]        cpu_data;
    logic              cpu_ack;
    logic [ROM_AW-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic [7:0]        mem_dout;
    logic              core_reset;
    logic [CNT_W-1:0]  byte_count;
    logic [7:0]        checksum;
    logic [7:0]        drop_count;

    modport slave (
        input  dn_download, dn_wr, dn_addr, dn_data, cpu_req, cpu_addr, mem_dout,
        output cpu_data, cpu_ack, mem_addr, mem_din, mem_we,
               core_reset, byte_count, checksum, drop_count
    );

    modport master (
        output dn_download, dn_wr, dn_addr, dn_data, cpu_req, cpu_addr, mem_dout,
        input  cpu_data, cpu_ack, mem_addr, mem_din, mem_we,
               core_reset, byte_count, checksum, drop_count
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// ROM download / game start sequencer. Owns the program-ROM BRAM port, giving the
// HPS loader absolute priority over CPU fetches, and holds the game core in reset
// until a full image has been loaded and a settle period has elapsed.
module rom_load_sequencer #(
    parameter int ROM_AW     = 16,
    parameter int SETTLE_CYC = 1024,
    parameter int CNT_W      = 17
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    rom_load_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {ST_HOLD, ST_LOAD, ST_SETTLE, ST_RUN} state_t;
    typedef enum logic [1:0] {F_IDLE, F_ADDR, F_DATA} fetch_t;

    localparam int              SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [16:0]     ADDR_LIMIT  = 17'(1) << ROM_AW;

    state_t            r_state, w_state_next;
    fetch_t            r_fetch, w_fetch_next;
    logic              r_dl_prev;
    logic [SW-1:0]     r_settle_cnt;

    logic [ROM_AW-1:0] r_mem_addr;
    logic [7:0]        r_mem_din;
    logic              r_mem_we;
    logic [7:0]        r_cpu_data;
    logic              r_cpu_ack;
    logic              r_core_reset;
    logic [CNT_W-1:0]  r_byte_count;
    logic [7:0]        r_checksum;
    logic [7:0]        r_drop_count;

    logic              w_dl_fall;
    logic              w_settle_done;
    logic              w_enter_load;
    logic              w_wr_accept;
    logic              w_wr_in_range;
    logic              w_fetch_accept;
    logic              w_fetch_done;

    assign w_dl_fall      = r_dl_prev & ~bus.dn_download;
    assign w_settle_done  = (r_settle_cnt == SETTLE_LAST);
    assign w_enter_load   = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);
    assign w_wr_accept    = (r_state == ST_LOAD) && bus.dn_wr;
    assign w_wr_in_range  = ({1'b0, bus.dn_addr} < ADDR_LIMIT);
    assign w_fetch_accept = (r_fetch == F_IDLE) && (w_fetch_next == F_ADDR);
    assign w_fetch_done   = (r_fetch == F_DATA) && (w_fetch_next == F_IDLE) && (r_state == ST_RUN)
                            && (w_state_next == ST_RUN);

    // Top-level state register plus download level history for fall detection.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_HOLD;
            r_fetch   <= F_IDLE;
            r_dl_prev <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_fetch   <= w_fetch_next;
            r_dl_prev <= bus.dn_download;
        end
    end

    // Next state: a new download preempts everything; a write coinciding with the fall still lands.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD:   if (bus.dn_download) w_state_next = ST_LOAD;
            ST_LOAD:   if (w_dl_fall)       w_state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (bus.dn_download)    w_state_next = ST_LOAD;
                else if (w_settle_done) w_state_next = ST_RUN;
            end
            ST_RUN:    if (bus.dn_download) w_state_next = ST_LOAD;
            default:   w_state_next = ST_HOLD;
        endcase
    end

    // Fetch sequencer: address cycle, data cycle, then idle; leaving RUN aborts silently.
    always_comb begin
        w_fetch_next = r_fetch;
        if ((r_state != ST_RUN) || (w_state_next != ST_RUN)) begin
            w_fetch_next = F_IDLE;
        end else begin
            case (r_fetch)
                F_IDLE:  if (bus.cpu_req) w_fetch_next = F_ADDR;
                F_ADDR:  w_fetch_next = F_DATA;
                F_DATA:  w_fetch_next = F_IDLE;
                default: w_fetch_next = F_IDLE;
            endcase
        end
    end

    // Settle timer runs only while staying in SETTLE and restarts from zero on every entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_settle_cnt <= '0;
        end else if ((r_state == ST_SETTLE) && (w_state_next == ST_SETTLE)) begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // Core reset tracks the registered state: released only while running.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_core_reset <= 1'b1;
        else          r_core_reset <= (w_state_next != ST_RUN);
    end

    // Load statistics, cleared on the cycle LOAD is entered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_drop_count <= '0;
        end else if (w_enter_load) begin
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_drop_count <= '0;
        end else if (w_wr_accept) begin
            if (w_wr_in_range) begin
                r_byte_count <= r_byte_count + CNT_W'(1);
                r_checksum   <= r_checksum + bus.dn_data;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // Shared BRAM port and CPU return path; loader writes and fetches never overlap in state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_cpu_data <= '0;
            r_cpu_ack  <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b0;
            if (w_wr_accept && w_wr_in_range) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= bus.dn_addr[ROM_AW-1:0];
                r_mem_din  <= bus.dn_data;
            end else if (w_fetch_accept) begin
                r_mem_addr <= bus.cpu_addr;
            end
            if (w_fetch_done) begin
                r_cpu_data <= bus.mem_dout;
                r_cpu_ack  <= 1'b1;
            end
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_we     = r_mem_we;
    assign bus.cpu_data   = r_cpu_data;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.core_reset = r_core_reset;
    assign bus.byte_count = r_byte_count;
    assign bus.checksum   = r_checksum;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: table-driven loads, scoreboarded BRAM writes and
// CPU acks, plus hand sequences for abort, saturation and reset mid-load.
module tb_rom_load_sequencer;
    localparam int ROM_AW     = 12;
    localparam int CNT_W      = 13;
    localparam int SETTLE_CYC = 8;
    localparam int NV         = 6;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    rom_load_sequencer_if #(.ROM_AW(ROM_AW), .CNT_W(CNT_W)) bus ();

    rom_load_sequencer #(
        .ROM_AW     (ROM_AW),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        int          grp;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        int          bc;
        logic [7:0]  cs;
        int          dc;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } ack_exp_t;

    vec_t     vecs [NV];
    wr_exp_t  wr_q [$];
    ack_exp_t ack_q [$];
    wr_exp_t  wr_e;
    ack_exp_t ack_e;

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int wr_pulses = 0;
    int ack_count = 0;

    logic [7:0] rom [0:(1<<ROM_AW)-1];

    // Registered-read BRAM model
    always @(posedge CLK) begin
        if (bus.mem_we === 1'b1) rom[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= rom[bus.mem_addr];
    end

    // Cycle counter used to time acks
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops expected writes and acks as the DUT produces them
    always @(negedge CLK) begin
        if (bus.mem_we === 1'b1) begin
            wr_pulses++;
            if (wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, expected none",
                         bus.mem_addr, bus.mem_din);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(wr_e.addr));
                check("wr_data", 32'(bus.mem_din), 32'(wr_e.data));
            end
        end
        if (bus.cpu_ack === 1'b1) begin
            ack_count++;
            if (ack_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ack_unexpected: got cpu_ack data 0x%0h at cycle %0d, expected none",
                         bus.cpu_data, cyc);
            end else begin
                ack_e = ack_q.pop_front();
                check("ack_data", 32'(bus.cpu_data), 32'(ack_e.data));
                check("ack_cycle", 32'(cyc), 32'(ack_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic exp_we, input logic fall);
        bus.dn_addr = a;
        bus.dn_data = d;
        bus.dn_wr   = 1'b1;
        if (fall) bus.dn_download = 1'b0;
        if (exp_we) wr_q.push_back('{a[11:0], d});
        @(posedge CLK); #1;
        bus.dn_wr = 1'b0;
    endtask

    // Entered #1 after the edge that moved the DUT into SETTLE
    task automatic check_settle();
        repeat (SETTLE_CYC - 1) @(posedge CLK);
        #1;
        check("settle_hold", 32'(bus.core_reset), 32'd1);
        @(posedge CLK); #1;
        check("settle_release", 32'(bus.core_reset), 32'd0);
    endtask

    task automatic do_load(input int g, input logic fall_last);
        int cnt_we = 0;
        int last_i = -1;
        logic fl;
        for (int i = 0; i < NV; i++) if (vecs[i].grp == g) last_i = i;
        bus.dn_download = 1'b1;
        @(posedge CLK); #1;
        check("entry_bc", 32'(bus.byte_count), 32'd0);
        check("entry_cs", 32'(bus.checksum), 32'd0);
        check("entry_dc", 32'(bus.drop_count), 32'd0);
        check("entry_core_reset", 32'(bus.core_reset), 32'd1);
        wr_pulses = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].grp == g) begin
                fl = fall_last && (i == last_i);
                wr(vecs[i].addr, vecs[i].data, vecs[i].we, fl);
                check("vec_bc", 32'(bus.byte_count), 32'(vecs[i].bc));
                check("vec_cs", 32'(bus.checksum), 32'(vecs[i].cs));
                check("vec_dc", 32'(bus.drop_count), 32'(vecs[i].dc));
                if (vecs[i].we) cnt_we++;
                if (!fl) begin @(posedge CLK); #1; end
            end
        end
        if (!fall_last) begin
            bus.dn_download = 1'b0;
            @(posedge CLK); #1;
        end
        check_settle();
        check("load_we_pulses", 32'(wr_pulses), 32'(cnt_we));
        check("load_wr_drain", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int c0;
        int ack_before;
        logic [7:0] sum;

        vecs[0] = '{0, 16'h1000, 8'h77, 1'b0, 0, 8'h00, 1};
        vecs[1] = '{0, 16'h0FFF, 8'hA5, 1'b1, 1, 8'hA5, 1};
        vecs[2] = '{1, 16'h0000, 8'h01, 1'b1, 1, 8'h01, 0};
        vecs[3] = '{1, 16'h0001, 8'h02, 1'b1, 2, 8'h03, 0};
        vecs[4] = '{1, 16'h0002, 8'h03, 1'b1, 3, 8'h06, 0};
        vecs[5] = '{1, 16'h0003, 8'hFF, 1'b1, 4, 8'h05, 0};

        bus.dn_download = 1'b0;
        bus.dn_wr       = 1'b0;
        bus.dn_addr     = '0;
        bus.dn_data     = '0;
        bus.cpu_req     = 1'b0;
        bus.cpu_addr    = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_core_reset", 32'(bus.core_reset), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_cpu_data", 32'(bus.cpu_data), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_din", 32'(bus.mem_din), 32'd0);
        check("rst_byte_count", 32'(bus.byte_count), 32'd0);
        check("rst_checksum", 32'(bus.checksum), 32'd0);
        check("rst_drop_count", 32'(bus.drop_count), 32'd0);
        RESET_N = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("hold_core_reset", 32'(bus.core_reset), 32'd1);

        // Out-of-range drop at the ROM boundary, then the basic 4-byte image with
        // the final write coinciding with the download fall.
        do_load(0, 1'b0);
        do_load(1, 1'b1);

        // Held request: acks 2 cycles after acceptance, then every 3 cycles
        bus.cpu_addr = 12'h002;
        bus.cpu_req  = 1'b1;
        c0 = cyc;
        ack_q.push_back('{8'h03, c0 + 3});
        ack_q.push_back('{8'h03, c0 + 6});
        ack_q.push_back('{8'h03, c0 + 9});
        while (cyc < c0 + 9) begin @(posedge CLK); #1; end
        bus.cpu_req = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("fetch_drain", 32'(ack_q.size()), 32'd0);

        // New download aborts an in-flight fetch
        ack_before   = ack_count;
        bus.cpu_addr = 12'h001;
        bus.cpu_req  = 1'b1;
        @(posedge CLK); #1;
        bus.cpu_req     = 1'b0;
        bus.dn_download = 1'b1;
        @(posedge CLK); #1;
        check("abort_core_reset", 32'(bus.core_reset), 32'd1);
        check("abort_bc", 32'(bus.byte_count), 32'd0);
        check("abort_cs", 32'(bus.checksum), 32'd0);
        check("abort_dc", 32'(bus.drop_count), 32'd0);
        repeat (5) @(posedge CLK);
        #1;
        check("abort_no_ack", 32'(ack_count), 32'(ack_before));

        // Drop counter saturation
        for (int i = 0; i < 300; i++) begin
            wr(16'h1000 + 16'(i * 37), 8'h5A, 1'b0, 1'b0);
            if (i == 253) check("drop_254", 32'(bus.drop_count), 32'd254);
            @(posedge CLK); #1;
        end
        check("drop_sat", 32'(bus.drop_count), 32'd255);
        check("drop_bc", 32'(bus.byte_count), 32'd0);

        // 300 in-range bytes, then asynchronous reset mid-load
        sum = '0;
        for (int i = 0; i < 300; i++) begin
            wr(16'(i), 8'(i * 7), 1'b1, 1'b0);
            sum = sum + 8'(i * 7);
            @(posedge CLK); #1;
        end
        check("big_bc", 32'(bus.byte_count), 32'd300);
        check("big_cs", 32'(bus.checksum), 32'(sum));
        check("big_wr_drain", 32'(wr_q.size()), 32'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst_bc", 32'(bus.byte_count), 32'd0);
        check("midrst_cs", 32'(bus.checksum), 32'd0);
        check("midrst_dc", 32'(bus.drop_count), 32'd0);
        check("midrst_core_reset", 32'(bus.core_reset), 32'd1);
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        bus.dn_download = 1'b0;
        bus.cpu_addr    = 12'h002;
        bus.cpu_req     = 1'b1;
        ack_before      = ack_count;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("hold_ignores_req", 32'(ack_count), 32'(ack_before));
        check("hold_after_rst", 32'(bus.core_reset), 32'd1);

        // Request held through load and settle is served only once running
        do_load(1, 1'b0);
        c0 = cyc;
        ack_q.push_back('{8'h03, c0 + 3});
        while (cyc < c0 + 3) begin @(posedge CLK); #1; end
        bus.cpu_req = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("late_fetch_drain", 32'(ack_q.size()), 32'd0);
        check("late_fetch_count", 32'(ack_count), 32'(ack_before + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
